exp6_unidade_controle: RTL and testbench

//  Moore FSM that sequences the memory-game datapath (limit/address counters, ROM, play/LED registers,

---
 rtl/exp6_unidade_controle.sv | 135 +++++++++++++
 tb/tb_exp6_unidade_controle.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp6_unidade_controle.sv
// Moore control unit for the memory game: sequences the show phase (ROM[0..limite] on the LEDs),
// then collects and checks the player's plays, growing the round by one item per success.
module exp6_unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       fimL,
    input  logic       fimTMR,
    input  logic       jogada_feita,
    input  logic       chavesIgualMemoria,
    input  logic       enderecoIgualLimite,
    input  logic       timeout,
    output logic       zeraR,
    output logic       zeraE,
    output logic       zeraL,
    output logic       zeraM,
    output logic       zeraTMR,
    output logic       registraR,
    output logic       registraM,
    output logic       contaE,
    output logic       contaL,
    output logic       contaTMR,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        ESPERA_ROM     = 4'h2,
        MOSTRA_DADO    = 4'h3,
        ESPERA_MOSTRA  = 4'h4,
        PROXIMO_MOSTRA = 4'h5,
        INICIA_JOGADAS = 4'h6,
        ESPERA_JOGADA  = 4'h7,
        REGISTRA       = 4'h8,
        COMPARACAO     = 4'h9,
        PROXIMA_JOGADA = 4'hA,
        PROXIMA_RODADA = 4'hB,
        ACERTOU        = 4'hC,
        ERROU          = 4'hD,
        FIM_TIMEOUT    = 4'hE,
        NAO_USADO      = 4'hF
    } estado_t;

    // Control vector layout, MSB first:
    // zeraR zeraE zeraL zeraM zeraTMR | registraR registraM contaE contaL contaTMR | pronto ganhou perdeu db_timeout
    localparam int CTRL_W = 14;

    estado_t             estado_r;
    estado_t             estado_prox_s;
    logic [CTRL_W-1:0]   ctrl_r;

    function automatic logic [CTRL_W-1:0] decodifica(input estado_t e);
        logic [CTRL_W-1:0] c;
        c = {CTRL_W{1'b0}};
        case (e)
            PREPARACAO:     c = 14'b11111_00000_0000;
            MOSTRA_DADO:    c = 14'b00000_01000_0000;
            ESPERA_MOSTRA:  c = 14'b00000_00001_0000;
            PROXIMO_MOSTRA: c = 14'b00001_00100_0000;
            INICIA_JOGADAS: c = 14'b11010_00000_0000;
            REGISTRA:       c = 14'b00000_10000_0000;
            PROXIMA_JOGADA: c = 14'b00000_00100_0000;
            PROXIMA_RODADA: c = 14'b01011_00010_0000;
            ACERTOU:        c = 14'b00000_00000_1100;
            ERROU:          c = 14'b00000_00000_1010;
            FIM_TIMEOUT:    c = 14'b00000_00000_1011;
            default:        c = {CTRL_W{1'b0}};
        endcase
        return c;
    endfunction

    // Next-state logic; iniciar only matters in the idle and end-of-game states.
    always_comb begin
        estado_prox_s = estado_r;
        case (estado_r)
            INICIAL: begin
                if (iniciar) estado_prox_s = PREPARACAO;
                else         estado_prox_s = INICIAL;
            end
            PREPARACAO:     estado_prox_s = ESPERA_ROM;
            ESPERA_ROM:     estado_prox_s = MOSTRA_DADO;
            MOSTRA_DADO:    estado_prox_s = ESPERA_MOSTRA;
            ESPERA_MOSTRA: begin
                if (!fimTMR)                  estado_prox_s = ESPERA_MOSTRA;
                else if (enderecoIgualLimite) estado_prox_s = INICIA_JOGADAS;
                else                          estado_prox_s = PROXIMO_MOSTRA;
            end
            PROXIMO_MOSTRA: estado_prox_s = ESPERA_ROM;
            INICIA_JOGADAS: estado_prox_s = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // A timeout in the same cycle as a press still counts as a loss.
                if (timeout)           estado_prox_s = FIM_TIMEOUT;
                else if (jogada_feita) estado_prox_s = REGISTRA;
                else                   estado_prox_s = ESPERA_JOGADA;
            end
            REGISTRA:       estado_prox_s = COMPARACAO;
            COMPARACAO: begin
                if (!chavesIgualMemoria)       estado_prox_s = ERROU;
                else if (!enderecoIgualLimite) estado_prox_s = PROXIMA_JOGADA;
                else if (fimL)                 estado_prox_s = ACERTOU;
                else                           estado_prox_s = PROXIMA_RODADA;
            end
            PROXIMA_JOGADA: estado_prox_s = ESPERA_JOGADA;
            PROXIMA_RODADA: estado_prox_s = ESPERA_ROM;
            ACERTOU, ERROU, FIM_TIMEOUT: begin
                if (iniciar) estado_prox_s = PREPARACAO;
                else         estado_prox_s = estado_r;
            end
            NAO_USADO:      estado_prox_s = INICIAL;
            default:        estado_prox_s = INICIAL;
        endcase
    end

    // State and control registers; controls are decoded from the next state so they always match estado_r.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_r <= INICIAL;
            ctrl_r   <= {CTRL_W{1'b0}};
        end else begin
            estado_r <= estado_prox_s;
            ctrl_r   <= decodifica(estado_prox_s);
        end
    end

    assign {zeraR, zeraE, zeraL, zeraM, zeraTMR,
            registraR, registraM, contaE, contaL, contaTMR,
            pronto, ganhou, perdeu, db_timeout} = ctrl_r;
    assign db_estado = estado_r;

endmodule

// File: tb/tb_exp6_unidade_controle.sv
// Directed bench for the memory-game control unit: walks every state path with hand-computed controls.
module tb_exp6_unidade_controle;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0, fimL = 1'b0, fimTMR = 1'b0, jogada_feita = 1'b0;
    logic       chavesIgualMemoria = 1'b0, enderecoIgualLimite = 1'b0, timeout = 1'b0;
    logic       zeraR, zeraE, zeraL, zeraM, zeraTMR, registraR, registraM;
    logic       contaE, contaL, contaTMR, pronto, ganhou, perdeu, db_timeout;
    logic [3:0] db_estado;
    logic [13:0] outs;

    int errors = 0;
    int checks = 0;

    // Expected control vectors, written out by hand from the state table.
    localparam logic [13:0] O_NONE   = 14'b00000_00000_0000;
    localparam logic [13:0] O_PREP   = 14'b11111_00000_0000;
    localparam logic [13:0] O_MOSTRA = 14'b00000_01000_0000;
    localparam logic [13:0] O_ESPERA = 14'b00000_00001_0000;
    localparam logic [13:0] O_PROXM  = 14'b00001_00100_0000;
    localparam logic [13:0] O_INICIA = 14'b11010_00000_0000;
    localparam logic [13:0] O_REG    = 14'b00000_10000_0000;
    localparam logic [13:0] O_PROXJ  = 14'b00000_00100_0000;
    localparam logic [13:0] O_PROXR  = 14'b01011_00010_0000;
    localparam logic [13:0] O_ACERTO = 14'b00000_00000_1100;
    localparam logic [13:0] O_ERRO   = 14'b00000_00000_1010;
    localparam logic [13:0] O_TMO    = 14'b00000_00000_1011;

    exp6_unidade_controle dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .fimL(fimL), .fimTMR(fimTMR),
        .jogada_feita(jogada_feita), .chavesIgualMemoria(chavesIgualMemoria),
        .enderecoIgualLimite(enderecoIgualLimite), .timeout(timeout),
        .zeraR(zeraR), .zeraE(zeraE), .zeraL(zeraL), .zeraM(zeraM), .zeraTMR(zeraTMR),
        .registraR(registraR), .registraM(registraM), .contaE(contaE), .contaL(contaL),
        .contaTMR(contaTMR), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
        .db_timeout(db_timeout), .db_estado(db_estado)
    );

    assign outs = {zeraR, zeraE, zeraL, zeraM, zeraTMR, registraR, registraM,
                   contaE, contaL, contaTMR, pronto, ganhou, perdeu, db_timeout};

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        iniciar = 1'b0; fimL = 1'b0; fimTMR = 1'b0; jogada_feita = 1'b0;
        chavesIgualMemoria = 1'b0; enderecoIgualLimite = 1'b0; timeout = 1'b0;
    endtask

    // Drives from any state through reset and a round-0 show, stopping in espera_jogada.
    task automatic go_to_play();
        clear_inputs();
        reset = 1'b1; tick(); reset = 1'b0;
        iniciar = 1'b1; tick(); iniciar = 1'b0;   // 1
        tick(); tick(); tick();                    // 2,3,4
        fimTMR = 1'b1; enderecoIgualLimite = 1'b1;
        tick();                                    // 6
        clear_inputs();
        tick();                                    // 7
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1; tick(); tick();
        checks++;
        if (db_estado !== 4'h0 || outs !== O_NONE) begin
            errors++; $display("FAIL reset_state: estado=%h outs=%b, expected 0 %b", db_estado, outs, O_NONE);
        end
        reset = 1'b0; tick();
        checks++;
        if (db_estado !== 4'h0 || outs !== O_NONE) begin
            errors++; $display("FAIL idle_hold: estado=%h outs=%b, expected 0 %b", db_estado, outs, O_NONE);
        end
    endtask

    task automatic test_start_show();
        logic [3:0]  exp_st [4]  = '{4'h1, 4'h2, 4'h3, 4'h4};
        logic [13:0] exp_o  [4]  = '{O_PREP, O_NONE, O_MOSTRA, O_ESPERA};
        iniciar = 1'b1; tick(); iniciar = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            checks++;
            if (db_estado !== exp_st[i] || outs !== exp_o[i]) begin
                errors++; $display("FAIL start_seq%0d: estado=%h outs=%b, expected %h %b",
                                   i, db_estado, outs, exp_st[i], exp_o[i]);
            end
        end
        tick();
        checks++;
        if (db_estado !== 4'h4 || outs !== O_ESPERA) begin
            errors++; $display("FAIL show_wait_hold: estado=%h, expected 4", db_estado);
        end
        // Not the last item: go through proximo_mostra back to espera_rom.
        fimTMR = 1'b1; enderecoIgualLimite = 1'b0; tick(); clear_inputs();
        checks++;
        if (db_estado !== 4'h5 || outs !== O_PROXM) begin
            errors++; $display("FAIL show_next: estado=%h outs=%b, expected 5 %b", db_estado, outs, O_PROXM);
        end
        tick();
        checks++;
        if (db_estado !== 4'h2) begin
            errors++; $display("FAIL show_next_rom: estado=%h, expected 2", db_estado);
        end
    endtask

    task automatic test_round0();
        logic [3:0]  exp_st [7] = '{4'h6, 4'h7, 4'h7, 4'h8, 4'h9, 4'hB, 4'h2};
        logic [13:0] exp_o  [7] = '{O_INICIA, O_NONE, O_NONE, O_REG, O_NONE, O_PROXR, O_NONE};
        clear_inputs();
        reset = 1'b1; tick(); reset = 1'b0;
        iniciar = 1'b1; tick(); iniciar = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 7; i++) begin
            clear_inputs();
            case (i)
                0: begin fimTMR = 1'b1; enderecoIgualLimite = 1'b1; end
                3: jogada_feita = 1'b1;
                5: begin chavesIgualMemoria = 1'b1; enderecoIgualLimite = 1'b1; end
                default: ;
            endcase
            tick();
            checks++;
            if (db_estado !== exp_st[i] || outs !== exp_o[i]) begin
                errors++; $display("FAIL round0_step%0d: estado=%h outs=%b, expected %h %b",
                                   i, db_estado, outs, exp_st[i], exp_o[i]);
            end
        end
    endtask

    task automatic test_reset_mid_play();
        go_to_play();
        checks++;
        if (db_estado !== 4'h7) begin
            errors++; $display("FAIL reach_play: estado=%h, expected 7", db_estado);
        end
        reset = 1'b1; jogada_feita = 1'b1; tick(); reset = 1'b0; clear_inputs();
        checks++;
        if (db_estado !== 4'h0 || outs !== O_NONE) begin
            errors++; $display("FAIL reset_mid_play: estado=%h outs=%b, expected 0 %b", db_estado, outs, O_NONE);
        end
    endtask

    task automatic test_timeout();
        go_to_play();
        timeout = 1'b1; jogada_feita = 1'b1; tick(); clear_inputs();
        checks++;
        if (db_estado !== 4'hE || outs !== O_TMO) begin
            errors++; $display("FAIL timeout_wins: estado=%h outs=%b, expected e %b", db_estado, outs, O_TMO);
        end
        tick();
        checks++;
        if (db_estado !== 4'hE) begin
            errors++; $display("FAIL timeout_hold: estado=%h, expected e", db_estado);
        end
        // Held iniciar restarts once, then is ignored while the new game runs.
        iniciar = 1'b1; tick();
        checks++;
        if (db_estado !== 4'h1 || outs !== O_PREP) begin
            errors++; $display("FAIL timeout_restart: estado=%h outs=%b, expected 1 %b", db_estado, outs, O_PREP);
        end
        tick(); tick();
        checks++;
        if (db_estado !== 4'h3) begin
            errors++; $display("FAIL iniciar_ignored: estado=%h, expected 3", db_estado);
        end
        clear_inputs();
    endtask

    task automatic test_errou();
        go_to_play();
        jogada_feita = 1'b1; tick(); clear_inputs(); tick();
        chavesIgualMemoria = 1'b0; enderecoIgualLimite = 1'b1; tick(); clear_inputs();
        checks++;
        if (db_estado !== 4'hD || outs !== O_ERRO) begin
            errors++; $display("FAIL errou: estado=%h outs=%b, expected d %b", db_estado, outs, O_ERRO);
        end
        iniciar = 1'b1; tick(); iniciar = 1'b0;
        checks++;
        if (db_estado !== 4'h1 || outs !== O_PREP) begin
            errors++; $display("FAIL errou_restart: estado=%h outs=%b, expected 1 %b", db_estado, outs, O_PREP);
        end
    endtask

    task automatic test_next_play();
        go_to_play();
        jogada_feita = 1'b1; tick(); clear_inputs(); tick();
        chavesIgualMemoria = 1'b1; enderecoIgualLimite = 1'b0; tick(); clear_inputs();
        checks++;
        if (db_estado !== 4'hA || outs !== O_PROXJ) begin
            errors++; $display("FAIL next_play: estado=%h outs=%b, expected a %b", db_estado, outs, O_PROXJ);
        end
        tick();
        checks++;
        if (db_estado !== 4'h7) begin
            errors++; $display("FAIL next_play_wait: estado=%h, expected 7", db_estado);
        end
    endtask

    task automatic test_full_game();
        int step_err = 0;
        int n_contaL = 0;
        logic [3:0] exp;
        clear_inputs();
        reset = 1'b1; tick(); reset = 1'b0;
        iniciar = 1'b1; tick(); iniciar = 1'b0;
        tick();
        for (int lim = 0; lim < 16; lim++) begin
            for (int i = 0; i <= lim; i++) begin
                if (db_estado !== 4'h2) step_err++;
                tick(); if (db_estado !== 4'h3) step_err++;
                tick(); if (db_estado !== 4'h4) step_err++;
                fimTMR = 1'b1; enderecoIgualLimite = (i == lim);
                tick(); clear_inputs();
                exp = (i == lim) ? 4'h6 : 4'h5;
                if (db_estado !== exp) step_err++;
                if (i != lim) tick();
            end
            tick();
            for (int i = 0; i <= lim; i++) begin
                if (db_estado !== 4'h7) step_err++;
                jogada_feita = 1'b1; tick(); clear_inputs();
                if (db_estado !== 4'h8) step_err++;
                tick();
                if (db_estado !== 4'h9) step_err++;
                chavesIgualMemoria = 1'b1; enderecoIgualLimite = (i == lim); fimL = (lim == 15);
                tick(); clear_inputs();
                exp = (i != lim) ? 4'hA : ((lim == 15) ? 4'hC : 4'hB);
                if (db_estado !== exp) step_err++;
                if (contaL) n_contaL++;
                if (db_estado != 4'hC) tick();
            end
        end
        checks++;
        if (step_err != 0) begin
            errors++; $display("FAIL full_game_path: %0d wrong states, expected 0", step_err);
        end
        checks++;
        if (n_contaL != 15) begin
            errors++; $display("FAIL full_game_contaL: %0d limit increments, expected 15", n_contaL);
        end
        checks++;
        if (db_estado !== 4'hC || outs !== O_ACERTO) begin
            errors++; $display("FAIL full_game_win: estado=%h outs=%b, expected c %b", db_estado, outs, O_ACERTO);
        end
        tick();
        checks++;
        if (db_estado !== 4'hC || contaL !== 1'b0 || ganhou !== 1'b1) begin
            errors++; $display("FAIL win_hold: estado=%h contaL=%b ganhou=%b, expected c 0 1", db_estado, contaL, ganhou);
        end
    endtask

    initial begin
        test_reset();
        test_start_show();
        test_round0();
        test_reset_mid_play();
        test_timeout();
        test_errou();
        test_next_play();
        test_full_game();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
